jt12_status: RTL
================

Name: jt12_status

Overview:
- Parametrised successor to the chip read-back multiplexer.
- Owns the sticky status flags (timer A/B, ADPCM-A per-channel end, ADPCM-B end), the write-busy timer and the IRQ line.
- Multiplexes them onto the CPU data bus according to chip flavour.
- Sits between the CPU interface and the timer/ADPCM/PSG units. Replaces the purely combinational read mux with registered, self-timed status logic.

Parameters:
- use_ssg, 0, 1 = addr 01 returns psg_dout
- use_adpcm, 0, 1 = addr 1x returns ADPCM flags; 0 = ADPCM flags are held at 0 and never set
- use_fifo, 0, 1 = bits 6/5 of the common status carry fifo_full/fifo_empty
- ADPCMA_CH, 6, number of ADPCM-A channels, legal range 1..6
- BUSY_CYCLES, 32, busy duration in cen ticks after a data write, legal range 1..255

Ports:
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  CPU clock
- cen  in  1  clock enable for the busy countdown
- wr  in  1  single-cycle CPU write strobe
- addr  in  2  CPU address
- flag_A_set  in  1  timer A overflow pulse
- flag_B_set  in  1  timer B overflow pulse
- flag_A_clr  in  1  clear timer A flag
- flag_B_clr  in  1  clear timer B flag
- adpcma_end  in  ADPCMA_CH  per-channel end pulses
- adpcma_clr  in  ADPCMA_CH  per-channel clear mask
- adpcmb_end  in  1  ADPCM-B end pulse
- adpcmb_clr  in  1  ADPCM-B clear
- irq_mask  in  ADPCMA_CH+3  enable bits, order {adpcmb, adpcma[], B, A}
- fifo_full  in  1  FIFO status
- fifo_empty  in  1  FIFO status
- psg_dout  in  8  SSG read data
- dout  out  8  registered read data
- busy  out  1  write-busy flag
- irq_n  out  1  registered active-low interrupt

Behaviour:
- Reset (rst_n low, asynchronous): dout=0, busy=0, busy counter=0, all sticky flags=0, irq_n=1. Any in-flight busy period is aborted.
- Sticky flags: set on the rising clk edge after a set pulse. Cleared the same way by the matching clr bit. Set and clr in the same cycle: set wins and the flag ends at 1.
- When use_adpcm=0, ADPCM flags are held at 0.
- Busy:
  - wr=1 with addr[0]=1 (data-port write): busy=1 next cycle, counter loaded with BUSY_CYCLES.
  - While counter is nonzero, each cycle with cen=1 decrements it. busy drops in the same cycle the counter reaches 0.
  - wr with addr[0]=1 while busy: counter reloads (restart) and busy stays 1.
  - wr with addr[0]=0 (address write) does not affect busy.
  - wr and cen in the same cycle: the reload wins.
- Common status byte: {busy, use_fifo?fifo_full:0, use_fifo?fifo_empty:0, 3'b0, flagB, flagA}. The busy, flagA and flagB bits read the registered values, not the next-state values.
- Read mux, registered every clk, latency 1 cycle from an addr change:
  - addr 00 -> common
  - addr 01 -> use_ssg ? psg_dout : common
  - addr 1x -> use_adpcm ? {adpcmb, 1'b0, adpcma zero-extended to 6 bits} : common
- irq_n = ~|(flags & irq_mask), registered: one cycle after the flag register updates, two cycles after the set pulse.
- Flags are never auto-cleared by reads.

Decomposition:
- Shared package jt12_status_pkg holds:
  - address constants ADDR_COMMON=2'b00, ADDR_SSG=2'b01, ADDR_ADPCM=2'b1?
  - status bit positions BUSY=7, FULL=6, EMPTY=5, FLAGB=1, FLAGA=0, ADPCMB=7
  - BUSY_CNT_W=8
- One sub-module jt12_status_busy: the reloadable down-counter with cen. Inputs: clk, rst_n, cen, load. Output: busy.

Test Plan:
- Reset mid-busy: write data, then assert rst_n low after 3 cen ticks -> busy=0, dout=0, irq_n=1 immediately. After release, the counter stays idle.
- Busy timing: BUSY_CYCLES=4, cen every cycle, wr with addr=01 at cycle 0 -> busy=1 for cycles 1..4, 0 at cycle 5. A second write at cycle 3 extends busy through cycle 7.
- Flag priority: flag_A_set and flag_A_clr together -> addr 00 reads 0x01 two cycles later. flag_A_clr alone on the next cycle -> reads 0x00.
- ADPCM read: use_adpcm=1, ADPCMA_CH=6, pulse adpcma_end=6'b100001 and adpcmb_end -> addr 10 reads 0xA1. Clear with adpcma_clr=6'b000001 -> reads 0xA0.
- IRQ mask: irq_mask={0,000000,1,0}; pulse flag_A_set -> irq_n stays 1. Pulse flag_B_set -> irq_n=0 two cycles after the pulse. flag_B_clr -> irq_n=1 two cycles later.
- Flavour mux: use_fifo=1, use_ssg=0, fifo_full=1, fifo_empty=0, busy=0 -> addr 00 and 01 both read 0x40. With use_ssg=1, psg_dout=0x5A -> addr 01 reads 0x5A.

Source files
------------

// File: rtl/jt12_status_pkg.sv
// Shared constants and helpers for the jt12 status/read-back block:
// address decode, status bit positions and busy counter width.
package jt12_status_pkg;

  localparam logic [1:0] ADDR_COMMON     = 2'b00;
  localparam logic [1:0] ADDR_SSG        = 2'b01;
  // The ADPCM window is 2'b1?: only the MSB is decoded.
  localparam logic [1:0] ADDR_ADPCM      = 2'b10;
  localparam logic [1:0] ADDR_ADPCM_MASK = 2'b10;

  localparam int BUSY   = 7;
  localparam int FULL   = 6;
  localparam int EMPTY  = 5;
  localparam int FLAGB  = 1;
  localparam int FLAGA  = 0;
  localparam int ADPCMB = 7;

  localparam int BUSY_CNT_W = 8;

  typedef enum logic [1:0] {
    SEL_COMMON = 2'd0,
    SEL_SSG    = 2'd1,
    SEL_ADPCM  = 2'd2
  } rd_sel_e;

  function automatic rd_sel_e decode_addr(input logic [1:0] a,
                                          input logic       ssg_en,
                                          input logic       adpcm_en);
    rd_sel_e sel;
    sel = SEL_COMMON;
    if (adpcm_en && ((a & ADDR_ADPCM_MASK) == ADDR_ADPCM))
      sel = SEL_ADPCM;
    else if (ssg_en && (a == ADDR_SSG))
      sel = SEL_SSG;
    else if (a == ADDR_COMMON)
      sel = SEL_COMMON;
    return sel;
  endfunction

  function automatic logic [7:0] common_byte(input logic b,
                                             input logic full,
                                             input logic empty,
                                             input logic fb,
                                             input logic fa);
    logic [7:0] v;
    v        = '0;
    v[BUSY]  = b;
    v[FULL]  = full;
    v[EMPTY] = empty;
    v[FLAGB] = fb;
    v[FLAGA] = fa;
    return v;
  endfunction

endpackage

// File: rtl/jt12_status_busy.sv
// Reloadable write-busy down-counter: a load restarts the full period,
// each cen tick counts down, busy is high while the count is nonzero.
module jt12_status_busy
  import jt12_status_pkg::*;
#(
  parameter int BUSY_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic load,
  output logic busy
);

  localparam logic [BUSY_CNT_W-1:0] LOAD_VAL = BUSY_CNT_W'(BUSY_CYCLES);

  logic [BUSY_CNT_W-1:0] r_cnt;

  // A reload takes priority over a coincident cen tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= LOAD_VAL;
    end else if (cen && (r_cnt != '0)) begin
      r_cnt <= r_cnt - BUSY_CNT_W'(1);
    end
  end

  assign busy = (r_cnt != '0);

endmodule

// File: rtl/jt12_status.sv
// Chip read-back block: sticky timer/ADPCM flags, write-busy timer,
// registered IRQ line and the flavour-dependent registered read mux.
module jt12_status
  import jt12_status_pkg::*;
#(
  parameter int use_ssg     = 0,
  parameter int use_adpcm   = 0,
  parameter int use_fifo    = 0,
  parameter int ADPCMA_CH   = 6,
  parameter int BUSY_CYCLES = 32
) (
  input  logic                 rst_n,
  input  logic                 clk,
  input  logic                 cen,
  input  logic                 wr,
  input  logic [1:0]           addr,
  input  logic                 flag_A_set,
  input  logic                 flag_B_set,
  input  logic                 flag_A_clr,
  input  logic                 flag_B_clr,
  input  logic [ADPCMA_CH-1:0] adpcma_end,
  input  logic [ADPCMA_CH-1:0] adpcma_clr,
  input  logic                 adpcmb_end,
  input  logic                 adpcmb_clr,
  input  logic [ADPCMA_CH+2:0] irq_mask,
  input  logic                 fifo_full,
  input  logic                 fifo_empty,
  input  logic [7:0]           psg_dout,
  output logic [7:0]           dout,
  output logic                 busy,
  output logic                 irq_n
);

  logic                 r_flag_a;
  logic                 r_flag_b;
  logic                 r_adpcmb;
  logic [ADPCMA_CH-1:0] r_adpcma;
  logic [7:0]           r_dout;
  logic                 r_irq_n;

  logic                 w_busy;
  logic [5:0]           w_adpcma6;
  logic [7:0]           w_adpcm_byte;
  logic [7:0]           w_common;
  logic [7:0]           w_rd;
  logic [ADPCMA_CH+2:0] w_flags;
  rd_sel_e              w_sel;

  jt12_status_busy #(
    .BUSY_CYCLES (BUSY_CYCLES)
  ) u_busy (
    .clk   (clk),
    .rst_n (rst_n),
    .cen   (cen),
    .load  (wr & addr[0]),
    .busy  (w_busy)
  );

  // Sticky flags: a set pulse beats a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flag_a <= 1'b0;
      r_flag_b <= 1'b0;
      r_adpcma <= '0;
      r_adpcmb <= 1'b0;
    end else begin
      r_flag_a <= flag_A_set | (r_flag_a & ~flag_A_clr);
      r_flag_b <= flag_B_set | (r_flag_b & ~flag_B_clr);
      if (use_adpcm != 0) begin
        r_adpcma <= adpcma_end | (r_adpcma & ~adpcma_clr);
        r_adpcmb <= adpcmb_end | (r_adpcmb & ~adpcmb_clr);
      end else begin
        r_adpcma <= '0;
        r_adpcmb <= 1'b0;
      end
    end
  end

  always_comb begin
    w_adpcma6 = '0;
    for (int i = 0; i < ADPCMA_CH; i++) begin
      w_adpcma6[i] = r_adpcma[i];
    end
    w_adpcm_byte         = '0;
    w_adpcm_byte[ADPCMB] = r_adpcmb;
    w_adpcm_byte[5:0]    = w_adpcma6;

    w_common = common_byte(w_busy,
                           (use_fifo != 0) & fifo_full,
                           (use_fifo != 0) & fifo_empty,
                           r_flag_b, r_flag_a);

    w_sel = decode_addr(addr, use_ssg != 0, use_adpcm != 0);
    w_rd  = w_common;
    case (w_sel)
      SEL_SSG:   w_rd = psg_dout;
      SEL_ADPCM: w_rd = w_adpcm_byte;
      default:   w_rd = w_common;
    endcase

    w_flags = {r_adpcmb, r_adpcma, r_flag_b, r_flag_a};
  end

  // Read data and IRQ are registered views of the flag/busy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout  <= '0;
      r_irq_n <= 1'b1;
    end else begin
      r_dout  <= w_rd;
      r_irq_n <= ~|(w_flags & irq_mask);
    end
  end

  assign dout  = r_dout;
  assign busy  = w_busy;
  assign irq_n = r_irq_n;

endmodule
